// File: rtl/fsk_pkg.sv
// Shared FSK timing constants and helpers, so the modulator and the deFSK
// demodulator agree on symbol length and tone half-periods.
package fsk_pkg;

  localparam int SYMBOL_CLKS = 32;
  localparam int HALF1       = 2;
  localparam int HALF0       = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } mod_state_e;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsk_mod_if.sv
// Word handshake into the FSK modulator: a word moves on a clk edge when
// data_valid && data_ready.
interface fsk_mod_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/fsk_tone_gen.sv
// Square-wave tone generator: starts high on restart and inverts every HALF
// clocks, where HALF is picked by the bit being sent.
module fsk_tone_gen #(
  parameter int HALF1 = fsk_pkg::HALF1,
  parameter int HALF0 = fsk_pkg::HALF0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_bit,
  output logic o_fsk
);

  localparam int TW = fsk_pkg::cnt_w((HALF1 > HALF0) ? HALF1 : HALF0);

  logic [TW-1:0] r_tone_cnt;
  logic [TW-1:0] w_half_m1;
  logic          r_fsk;

  assign w_half_m1 = i_bit ? TW'(HALF1 - 1) : TW'(HALF0 - 1);
  assign o_fsk     = r_fsk;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsk      <= 1'b0;
      r_tone_cnt <= '0;
    end else if (i_restart) begin
      r_fsk      <= 1'b1;
      r_tone_cnt <= '0;
    end else if (r_tone_cnt == w_half_m1) begin
      r_fsk      <= ~r_fsk;
      r_tone_cnt <= '0;
    end else begin
      r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_mod.sv
// Byte-serial FSK modulator: takes words over a valid/ready handshake, keeps a
// one-word holding register, and sends each bit MSB first as a fixed-length tone.
module fsk_mod #(
  parameter int DATA_W      = 8,
  parameter int SYMBOL_CLKS = fsk_pkg::SYMBOL_CLKS,
  parameter int HALF1       = fsk_pkg::HALF1,
  parameter int HALF0       = fsk_pkg::HALF0
) (
  input  logic            clk,
  input  logic            rst,
  fsk_mod_if.slave        s_if,
  output logic            fsk_out,
  output logic            bit_out,
  output logic            sym_strobe,
  output logic            busy
);

  localparam int SW = fsk_pkg::cnt_w(SYMBOL_CLKS);
  localparam int BW = fsk_pkg::cnt_w(DATA_W);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_CLKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  fsk_pkg::mod_state_e r_state, w_state_nxt;

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_vld;
  logic [SW-1:0]     r_sym_cnt;
  logic [BW-1:0]     r_bit_idx;
  logic              r_sym_strobe;

  logic w_ready, w_accept, w_sym_wrap, w_last;
  logic w_bypass, w_hold_load, w_hold_wr, w_sym_start, w_tone_clr;

  assign w_ready         = !r_hold_vld && !rst;
  assign s_if.data_ready = w_ready;
  assign w_accept        = s_if.data_valid && w_ready;

  assign w_sym_wrap  = (r_state == fsk_pkg::ST_SEND) && (r_sym_cnt == SYM_LAST);
  assign w_last      = w_sym_wrap && (r_bit_idx == BIT_LAST);
  // A word taken while idle, or on the final edge of a word with the hold
  // register empty, goes straight to the shifter so no symbol slot is lost.
  assign w_bypass    = w_accept && ((r_state == fsk_pkg::ST_IDLE) || w_last);
  assign w_hold_load = w_last && r_hold_vld;
  assign w_hold_wr   = w_accept && (r_state == fsk_pkg::ST_SEND) && !w_last;
  assign w_sym_start = w_bypass || w_hold_load || (w_sym_wrap && !w_last);
  assign w_tone_clr  = rst || (w_state_nxt == fsk_pkg::ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= fsk_pkg::ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment ahead of the case keeps every path assigned,
  // so no latch is inferred for the next-state signal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      fsk_pkg::ST_IDLE: if (w_accept) w_state_nxt = fsk_pkg::ST_SEND;
      fsk_pkg::ST_SEND: if (w_last && !w_hold_load && !w_bypass) w_state_nxt = fsk_pkg::ST_IDLE;
      default:          w_state_nxt = fsk_pkg::ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == fsk_pkg::ST_SEND);
    sym_strobe = r_sym_strobe;
    bit_out    = r_shift[DATA_W-1];
  end

  // NOTE: the hold and shift registers are cleared on reset as well, so a word
  // caught mid-flight can never resurface after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_sym_cnt    <= '0;
      r_bit_idx    <= '0;
      r_sym_strobe <= 1'b0;
    end else begin
      r_sym_strobe <= w_sym_start;

      if (w_bypass)         r_shift <= s_if.data_in;
      else if (w_hold_load) r_shift <= r_hold;
      else if (w_sym_wrap)  r_shift <= {r_shift[DATA_W-2:0], 1'b0};

      if (w_hold_load) begin
        r_hold_vld <= 1'b0;
      end else if (w_hold_wr) begin
        r_hold     <= s_if.data_in;
        r_hold_vld <= 1'b1;
      end

      if (w_sym_wrap || (r_state == fsk_pkg::ST_IDLE)) r_sym_cnt <= '0;
      else                                              r_sym_cnt <= r_sym_cnt + 1'b1;

      if (w_bypass || w_last) r_bit_idx <= '0;
      else if (w_sym_wrap)    r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  fsk_tone_gen #(
    .HALF1 (HALF1),
    .HALF0 (HALF0)
  ) u_tone (
    .clk       (clk),
    .rst       (w_tone_clr),
    .i_restart (w_sym_start),
    .i_bit     (bit_out),
    .o_fsk     (fsk_out)
  );

endmodule

// File: tb/tb_fsk_mod.sv
// Self-checking bench for fsk_mod: table-driven single words plus hand-written
// back-to-back, last-edge bypass, backpressure and mid-symbol reset sequences.
module tb_fsk_mod;

  localparam int LOG_N = 1024;

  logic clk = 1'b0;
  logic rst;
  logic fsk_out, bit_out, sym_strobe, busy;

  fsk_mod_if #(.DATA_W(8)) bus ();

  fsk_mod #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (bus),
    .fsk_out    (fsk_out),
    .bit_out    (bit_out),
    .sym_strobe (sym_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int base;
  int acc_a, acc_b;

  logic fsk_log [LOG_N];
  logic bit_log [LOG_N];
  logic stb_log [LOG_N];
  logic busy_log[LOG_N];
  logic rdy_log [LOG_N];

  typedef struct {
    logic [7:0] word;
    logic [7:0] bits;    // expected bit_out sequence, first symbol in bit 7
    int         pulses;  // high pulses of fsk_out over the whole word
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference tone: '1' is high 2 / low 2, '0' is high 1 / low 1, starting high.
  function automatic logic [31:0] tone_model(input logic b);
    logic [31:0] v;
    for (int k = 0; k < 32; k++)
      v[31-k] = b ? (((k / 2) % 2) == 0) : ((k % 2) == 0);
    return v;
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < LOG_N) begin
        fsk_log[i]  = fsk_out;
        bit_log[i]  = bit_out;
        stb_log[i]  = sym_strobe;
        busy_log[i] = busy;
        rdy_log[i]  = bus.data_ready;
      end
      step();
    end
  endtask

  task automatic check_word(input int off, input logic [7:0] bits, input string tag);
    for (int s = 0; s < 8; s++) begin
      logic [31:0] gf, gb, gs, gy;
      for (int k = 0; k < 32; k++) begin
        gf[31-k] = fsk_log[off + s*32 + k];
        gb[31-k] = bit_log[off + s*32 + k];
        gs[31-k] = stb_log[off + s*32 + k];
        gy[31-k] = busy_log[off + s*32 + k];
      end
      check($sformatf("%s_sym%0d_fsk", tag, s), gf, tone_model(bits[7-s]));
      check($sformatf("%s_sym%0d_bit", tag, s), gb, {32{bits[7-s]}});
      check($sformatf("%s_sym%0d_strobe", tag, s), gs, 32'h8000_0000);
      check($sformatf("%s_sym%0d_busy", tag, s), gy, 32'hFFFF_FFFF);
    end
  endtask

  function automatic int count_pulses(input int off);
    int n = 0;
    for (int i = off; i < off + 256; i++)
      if (fsk_log[i] && (i == off || !fsk_log[i-1])) n++;
    return n;
  endfunction

  // Offer a word after 'delay' cycles and hold it until taken; acc is the
  // accepting edge counted from the edge that started the current word.
  task automatic feed(input logic [7:0] w, input int delay, output int acc);
    repeat (delay) step();
    bus.data_valid = 1'b1;
    bus.data_in    = w;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.data_ready) begin
        step();
        acc = cyc - base;
        break;
      end
      step();
    end
    bus.data_valid = 1'b0;
    check($sformatf("feed_%02h_taken", w), 32'(acc >= 0), 32'd1);
  endtask

  // Offer a word while idle; returns just after the accepting edge.
  task automatic start_word(input logic [7:0] w, input string tag);
    bus.data_valid = 1'b1;
    bus.data_in    = w;
    check({tag, "_ready_idle"}, 32'(bus.data_ready), 32'd1);
    check({tag, "_fsk_pre"}, 32'(fsk_out), 32'd0);
    step();
    base = cyc;
    bus.data_valid = 1'b0;
  endtask

  task automatic run_single(input logic [7:0] w, input logic [7:0] bits, input int pulses,
                            input string tag);
    int strobes = 0;
    start_word(w, tag);
    capture(264);
    check_word(0, bits, tag);
    for (int i = 0; i < 264; i++) if (stb_log[i]) strobes++;
    check({tag, "_strobe_count"}, 32'(strobes), 32'd8);
    check({tag, "_pulses"}, 32'(count_pulses(0)), 32'(pulses));
    check({tag, "_busy_end"}, 32'(busy_log[256]), 32'd0);
    check({tag, "_fsk_end"}, 32'(fsk_log[256]), 32'd0);
    check({tag, "_ready_end"}, 32'(rdy_log[256]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad_fsk, bad_busy, bad_rdy;

    vecs[0] = '{word: 8'hA5, bits: 8'b1010_0101, pulses: 96};
    vecs[1] = '{word: 8'h3C, bits: 8'b0011_1100, pulses: 96};
    vecs[2] = '{word: 8'h80, bits: 8'b1000_0000, pulses: 120};
    vecs[3] = '{word: 8'h01, bits: 8'b0000_0001, pulses: 120};
    vecs[4] = '{word: 8'hFF, bits: 8'b1111_1111, pulses: 64};

    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    repeat (3) step();
    check("rst_fsk", 32'(fsk_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bit", 32'(bit_out), 32'd0);
    check("rst_strobe", 32'(sym_strobe), 32'd0);
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    rst = 1'b0;

    // Idle for 100 clocks.
    bad_fsk = 0; bad_busy = 0; bad_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fsk_out) bad_fsk++;
      if (busy) bad_busy++;
      if (!bus.data_ready) bad_rdy++;
    end
    check("idle_fsk_high", 32'(bad_fsk), 32'd0);
    check("idle_busy_high", 32'(bad_busy), 32'd0);
    check("idle_ready_low", 32'(bad_rdy), 32'd0);

    for (int v = 0; v < 5; v++)
      run_single(vecs[v].word, vecs[v].bits, vecs[v].pulses, $sformatf("vec%0d", v));

    // Back-to-back: 0x00 queued early goes to hold, played gapless at offset 256.
    start_word(8'hFF, "b2b");
    fork
      capture(520);
      feed(8'h00, 3, acc_a);
    join
    check("b2b_accept_edge", 32'(acc_a), 32'd4);
    check_word(0, 8'hFF, "b2b_w0");
    check_word(256, 8'h00, "b2b_w1");
    bad_rdy = 0;
    for (int i = 4; i < 256; i++) if (!rdy_log[i]) bad_rdy++;
    check("b2b_ready_low_cycles", 32'(bad_rdy), 32'd252);
    check("b2b_ready_back", 32'(rdy_log[256]), 32'd1);
    check("b2b_busy_end", 32'(busy_log[512]), 32'd0);
    check("b2b_fsk_end", 32'(fsk_log[512]), 32'd0);

    // Word offered on the last clock of a word with hold empty: bypass, no gap.
    start_word(8'h0F, "byp");
    fork
      capture(520);
      feed(8'hF0, 255, acc_a);
    join
    check("byp_accept_edge", 32'(acc_a), 32'd256);
    check_word(0, 8'h0F, "byp_w0");
    check_word(256, 8'hF0, "byp_w1");
    check("byp_busy_end", 32'(busy_log[512]), 32'd0);

    // Backpressure: third word waits until the hold register empties.
    start_word(8'h11, "bp");
    fork
      capture(780);
      begin
        feed(8'h22, 2, acc_a);
        feed(8'h33, 7, acc_b);
      end
    join
    check("bp_w2_accept_edge", 32'(acc_a), 32'd3);
    check("bp_w3_accept_edge", 32'(acc_b), 32'd257);
    check("bp_ready_while_full", 32'(rdy_log[100]), 32'd0);
    check_word(0, 8'h11, "bp_w0");
    check_word(256, 8'h22, "bp_w1");
    check_word(512, 8'h33, "bp_w2");
    check("bp_busy_end", 32'(busy_log[768]), 32'd0);

    // Reset at clock 40 of a word with another word sitting in hold.
    start_word(8'hC3, "rst");
    repeat (2) step();
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h3C;
    check("rst_hold_ready", 32'(bus.data_ready), 32'd1);
    step();
    bus.data_valid = 1'b0;
    check("rst_hold_full_ready", 32'(bus.data_ready), 32'd0);
    repeat (37) step();
    check("rst_pre_fsk", 32'(fsk_out), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_fsk", 32'(fsk_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(bus.data_ready), 32'd0);
    check("rst_mid_bit", 32'(bit_out), 32'd0);
    check("rst_mid_strobe", 32'(sym_strobe), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.data_ready), 32'd1);
    bad_fsk = 0; bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fsk_out) bad_fsk++;
      if (busy) bad_busy++;
    end
    check("rst_after_fsk_high", 32'(bad_fsk), 32'd0);
    check("rst_after_busy_high", 32'(bad_busy), 32'd0);
    run_single(8'h80, 8'b1000_0000, 120, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
